// File: rtl/sha3_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sha3_fifo_pkg
// Shared constants and types for the SHA3 lane FIFO.
//   LANE_W        : width of one Keccak lane in bits
//   DEFAULT_DEPTH : default number of FIFO entries
//   fifo_status_t : bundle of the FIFO status flags
// -----------------------------------------------------------------------------
package sha3_fifo_pkg;

  localparam int LANE_W        = 64;
  localparam int DEFAULT_DEPTH = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic ovf;
    logic udf;
  } fifo_status_t;

endpackage

// File: rtl/sha3_stream_fifo_if.sv
// -----------------------------------------------------------------------------
// sha3_stream_fifo_if
// Bus between the padding front-end / Keccak absorb stage and the lane FIFO.
//   master : drives fifo_flush, fifo_in, fifo_wr, fifo_rd; observes data/status
//   slave  : the FIFO itself; drives fifo_out, status flags and fifo_level
// -----------------------------------------------------------------------------
interface sha3_stream_fifo_if
  import sha3_fifo_pkg::*;
#(
  parameter int WIDTH = LANE_W,
  parameter int DEPTH = DEFAULT_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              fifo_flush;
  logic [WIDTH-1:0]  fifo_in;
  logic              fifo_wr;
  logic              fifo_rd;
  logic [WIDTH-1:0]  fifo_out;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_afull;
  logic              fifo_aempty;
  logic [ADDR_W:0]   fifo_level;
  logic              fifo_ovf;
  logic              fifo_udf;

  modport master (
    output fifo_flush, fifo_in, fifo_wr, fifo_rd,
    input  fifo_out, fifo_full, fifo_empty, fifo_afull, fifo_aempty,
           fifo_level, fifo_ovf, fifo_udf
  );

  modport slave (
    input  fifo_flush, fifo_in, fifo_wr, fifo_rd,
    output fifo_out, fifo_full, fifo_empty, fifo_afull, fifo_aempty,
           fifo_level, fifo_ovf, fifo_udf
  );

endinterface

// File: rtl/sha3_fifo_mem.sv
// -----------------------------------------------------------------------------
// sha3_fifo_mem
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port.
//   clk        : clock, rising edge
//   wr_en_i    : write enable
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address
//   rd_data_o  : read data (combinational from rd_addr_i)
// -----------------------------------------------------------------------------
module sha3_fifo_mem #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the pointers and level,
  // so clearing storage would only cost a reset fan-out to every bit.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sha3_stream_fifo.sv
// -----------------------------------------------------------------------------
// sha3_stream_fifo
// Synchronous lane FIFO between the SHA3 padding front-end and the Keccak
// absorb stage. Standard (registered, 1-cycle latency) or FWFT read mode,
// fill level, almost-full/almost-empty, synchronous flush, sticky error flags.
//   clk      : clock, rising edge
//   reset_n  : asynchronous reset, active low
//   fifo_if  : slave side of sha3_stream_fifo_if
//              (flush/in/wr/rd in; out/full/empty/afull/aempty/level/ovf/udf out)
// -----------------------------------------------------------------------------
module sha3_stream_fifo
  import sha3_fifo_pkg::*;
#(
  parameter int WIDTH     = LANE_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter bit FWFT      = 1'b0,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input logic               clk,
  input logic               reset_n,
  sha3_stream_fifo_if.slave fifo_if
);

  localparam logic [ADDR_W:0] LVL_FULL   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_AFULL  = (ADDR_W + 1)'(AFULL_TH);
  localparam logic [ADDR_W:0] LVL_AEMPTY = (ADDR_W + 1)'(AEMPTY_TH);

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic              ovf_q, udf_q;
  logic              rd_ok, wr_ok;
  logic [WIDTH-1:0]  rd_data;
  fifo_status_t      status;

  // Status comes only from registered state, never from the request inputs.
  always_comb begin
    status.full   = (level_q == LVL_FULL);
    status.empty  = (level_q == '0);
    status.afull  = (level_q >= LVL_AFULL);
    status.aempty = (level_q <= LVL_AEMPTY);
    status.ovf    = ovf_q;
    status.udf    = udf_q;
  end

  // A write into a full FIFO is fine when a pop frees a slot in the same cycle.
  // Flush suppresses both requests entirely.
  assign rd_ok = fifo_if.fifo_rd & ~status.empty & ~fifo_if.fifo_flush;
  assign wr_ok = fifo_if.fifo_wr & (~status.full | rd_ok) & ~fifo_if.fifo_flush;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves level_d unassigned (no latch).
    level_d = level_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
      2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else if (fifo_if.fifo_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      // Power-of-two depth: pointers wrap DEPTH-1 -> 0 by natural overflow.
      if (wr_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      if (fifo_if.fifo_wr & ~wr_ok) ovf_q <= 1'b1;
      if (fifo_if.fifo_rd & ~rd_ok) udf_q <= 1'b1;
    end
  end

  sha3_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (fifo_if.fifo_in),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  generate
    if (FWFT) begin : g_fwft
      // Head word is always presented; meaningless (but stable) while empty.
      assign fifo_if.fifo_out = rd_data;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dout_q <= '0;
        end else if (fifo_if.fifo_flush) begin
          dout_q <= '0;
        end else if (rd_ok) begin
          dout_q <= rd_data;
        end
      end
      assign fifo_if.fifo_out = dout_q;
    end
  endgenerate

  assign fifo_if.fifo_full   = status.full;
  assign fifo_if.fifo_empty  = status.empty;
  assign fifo_if.fifo_afull  = status.afull;
  assign fifo_if.fifo_aempty = status.aempty;
  assign fifo_if.fifo_ovf    = status.ovf;
  assign fifo_if.fifo_udf    = status.udf;
  assign fifo_if.fifo_level  = level_q;

endmodule

// File: tb/tb_sha3_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_sha3_stream_fifo
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus. A
// queue-based reference model predicts level, flags and popped words; popped
// words go to per-DUT scoreboards checked by independent monitors.
// -----------------------------------------------------------------------------
module tb_sha3_stream_fifo;

  localparam int WIDTH     = 64;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = DEPTH - 2;
  localparam int AEMPTY_TH = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sha3_stream_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_s ();
  sha3_stream_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_f ();

  sha3_stream_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b0),
    .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
  ) u_std (
    .clk(clk), .reset_n(reset_n), .fifo_if(bus_s)
  );

  sha3_stream_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b1),
    .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
  ) u_fwft (
    .clk(clk), .reset_n(reset_n), .fifo_if(bus_f)
  );

  // Reference model: contents as a plain queue, sticky flags, last popped word.
  logic [WIDTH-1:0] m_q [$];
  bit               m_ovf, m_udf;
  logic [WIDTH-1:0] m_out;
  // Scoreboards of words expected to be popped, one per DUT.
  logic [WIDTH-1:0] exp_s [$];
  logic [WIDTH-1:0] exp_f [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit wr, input bit rd, input bit flush, input logic [WIDTH-1:0] din);
    bus_s.fifo_wr = wr;  bus_f.fifo_wr = wr;
    bus_s.fifo_rd = rd;  bus_f.fifo_rd = rd;
    bus_s.fifo_flush = flush;  bus_f.fifo_flush = flush;
    bus_s.fifo_in = din;  bus_f.fifo_in = din;
  endtask

  function automatic logic [WIDTH-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_out = '0;
  endtask

  task automatic check_status(input string tag);
    int n;
    logic [5:0] ef;
    n  = m_q.size();
    ef = {n == DEPTH, n == 0, n >= AFULL_TH, n <= AEMPTY_TH, m_ovf, m_udf};
    check({tag, "_std_level"}, 64'(bus_s.fifo_level), 64'(n));
    check({tag, "_std_flags"}, 64'({bus_s.fifo_full, bus_s.fifo_empty, bus_s.fifo_afull,
                                    bus_s.fifo_aempty, bus_s.fifo_ovf, bus_s.fifo_udf}), 64'(ef));
    check({tag, "_fwft_level"}, 64'(bus_f.fifo_level), 64'(n));
    check({tag, "_fwft_flags"}, 64'({bus_f.fifo_full, bus_f.fifo_empty, bus_f.fifo_afull,
                                     bus_f.fifo_aempty, bus_f.fifo_ovf, bus_f.fifo_udf}), 64'(ef));
  endtask

  // One clock of stimulus: called just after a rising edge, applies inputs,
  // advances the model, waits for the edge and compares status.
  task automatic step(input bit wr, input bit rd, input logic [WIDTH-1:0] din,
                      input bit flush, input string tag);
    bit rd_ok, wr_ok;
    logic [WIDTH-1:0] w;
    drive(wr, rd, flush, din);
    if (flush) begin
      model_clear();
    end else begin
      rd_ok = rd && (m_q.size() != 0);
      wr_ok = wr && ((m_q.size() < DEPTH) || rd_ok);
      if (rd_ok) begin
        w = m_q.pop_front();
        exp_s.push_back(w);
        exp_f.push_back(w);
        m_out = w;
      end else if (rd) begin
        m_udf = 1'b1;
      end
      if (wr_ok) m_q.push_back(din);
      else if (wr) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_status(tag);
  endtask

  // Standard-mode monitor: an accepted read shows its word after the next edge.
  initial begin : mon_std
    forever begin
      @(negedge clk);
      if (reset_n && bus_s.fifo_rd && !bus_s.fifo_empty && !bus_s.fifo_flush) begin
        @(posedge clk);
        #2;
        if (exp_s.size() == 0) check("std_sb_underrun", 64'(exp_s.size()), 64'd1);
        else check("std_data", bus_s.fifo_out, exp_s.pop_front());
      end
    end
  end

  // FWFT monitor: the word being popped is on fifo_out before the edge.
  initial begin : mon_fwft
    forever begin
      @(negedge clk);
      if (reset_n && bus_f.fifo_rd && !bus_f.fifo_empty && !bus_f.fifo_flush) begin
        if (exp_f.size() == 0) check("fwft_sb_underrun", 64'(exp_f.size()), 64'd1);
        else check("fwft_data", bus_f.fifo_out, exp_f.pop_front());
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [WIDTH-1:0] d;
    bit wr, rd, fl;
    drive(1'b0, 1'b0, 1'b0, '0);
    model_clear();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_std_out", bus_s.fifo_out, 64'd0);
    check_status("rst");
    reset_n = 1'b1;

    // Fill to full, then one rejected write.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 64'(i), 1'b0, "t1_wr");
    step(1'b1, 1'b0, 64'd99, 1'b0, "t1_ovf");

    // Drain, then one rejected read; output holds the last word.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, 1'b0, "t2_rd");
    step(1'b0, 1'b1, '0, 1'b0, "t2_udf");
    check("t2_hold", bus_s.fifo_out, 64'd15);

    step(1'b0, 1'b0, '0, 1'b1, "flush1");
    check("flush1_std_out", bus_s.fifo_out, 64'd0);

    // Full with simultaneous write and read.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, rnd64(), 1'b0, "t3_fill");
    step(1'b1, 1'b1, 64'hAA, 1'b0, "t3_both");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, 1'b0, "t3_rd");
    check("t3_last_aa", bus_s.fifo_out, 64'hAA);

    // Level bouncing between 2 and 3 across pointer wrap.
    step(1'b0, 1'b0, '0, 1'b1, "flush2");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rnd64(), 1'b0, "t4_pre");
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b1, '0, 1'b0, "t4_pop");
      else            step(1'b1, 1'b0, rnd64(), 1'b0, "t4_push");
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, 1'b0, "t4_drain");

    // FWFT head visibility.
    step(1'b0, 1'b0, '0, 1'b1, "flush3");
    step(1'b1, 1'b0, 64'h1234, 1'b0, "t5_wr");
    check("t5_fwft_head", bus_f.fifo_out, 64'h1234);
    step(1'b1, 1'b0, 64'h5678, 1'b0, "t5_wr2");
    step(1'b0, 1'b1, '0, 1'b0, "t5_pop");
    check("t5_fwft_next", bus_f.fifo_out, 64'h5678);
    step(1'b0, 1'b1, '0, 1'b0, "t5_pop2");

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 300; i++) begin
      wr = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) == 0);
      step(wr, rd, rnd64(), fl, "rand");
    end

    // Flush at level 9 with ovf set and a write pending.
    step(1'b0, 1'b0, '0, 1'b1, "flush4");
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, rnd64(), 1'b0, "t6_fill");
    step(1'b1, 1'b0, rnd64(), 1'b0, "t6_ovf");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, '0, 1'b0, "t6_rd");
    step(1'b1, 1'b0, rnd64(), 1'b1, "t6_flush");
    check("t6_flush_std_out", bus_s.fifo_out, 64'd0);

    // Async reset at level 5 in the middle of a write.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rnd64(), 1'b0, "t6_refill");
    d = rnd64();
    drive(1'b1, 1'b0, 1'b0, d);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    check_status("t6_rst");
    check("t6_rst_std_out", bus_s.fifo_out, 64'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, '0);
    reset_n = 1'b1;
    // Only the post-reset word may come out.
    step(1'b1, 1'b0, 64'hBEEF, 1'b0, "t6_post_wr");
    step(1'b0, 1'b1, '0, 1'b0, "t6_post_rd");
    step(1'b0, 1'b1, '0, 1'b0, "t6_post_udf");
    check("t6_post_std_out", bus_s.fifo_out, 64'hBEEF);

    drive(1'b0, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("sb_std_drained", 64'(exp_s.size()), 64'd0);
    check("sb_fwft_drained", 64'(exp_f.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
